uart_cfg: RTL

Parametrised, runtime-configurable UART. It is the successor to the fixed 8N1 transmitter/receiver pair and adds:
- configurable data width, parity mode and stop-bit count;
- a runtime baud divisor;
- a 16x-oversampled, mid-bit-sampling receiver with a synchroniser;
- a valid/ready transmit handshake;
- framing and parity error flags.

It sits between the board serial pins and the system bus logic, in the single clock domain.

---
 rtl/uart_cfg.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cfg.sv
// uart_cfg: runtime-configurable UART transmitter/receiver, single clock domain.
//
// Ports:
//   clk, rst        system clock; asynchronous active-high reset
//   baud_div        oversample tick period in clk cycles (0 behaves as 1)
//   parity_mode     00/11 none, 01 even, 10 odd
//   stop2           transmit two stop bits
//   tx_valid/ready  transmit handshake; transfer when both high
//   tx_data         payload to send, LSB first
//   tx              serial output, idles high
//   rx              asynchronous serial input
//   rx_valid        one-cycle pulse qualifying rx_data and the error flags
//   rx_data         last received payload
//   rx_parity_err   parity mismatch on the last frame
//   rx_frame_err    stop bit sampled low on the last frame
//   rx_busy         receiver is inside a frame
module uart_cfg #(
    parameter int unsigned SYS_CLK_RATE = 50000000,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned DIV_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int unsigned      IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    // Elaboration-time guard on the supported parameter range.
    if (DATA_BITS < 5 || DATA_BITS > 8 || SYS_CLK_RATE == 0) begin : g_bad_param
        $error("uart_cfg: DATA_BITS must be 5..8 and SYS_CLK_RATE nonzero");
    end

    // Effective divisor and parity decode shared by both directions.
    logic [DIV_W-1:0] div_eff_c;
    logic             par_en_c;
    assign div_eff_c = (baud_div == '0) ? DIV_ONE : baud_div;
    assign par_en_c  = parity_mode[0] ^ parity_mode[1];

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    tx_state_t              tx_state, tx_state_nxt;
    logic [DIV_W-1:0]       tx_div, tx_div_cnt;
    logic [3:0]             tx_tick_cnt;
    logic [IDX_W-1:0]       tx_idx, tx_idx_nxt;
    logic [DATA_BITS-1:0]   tx_shreg, tx_shreg_nxt;
    logic                   tx_par_en, tx_par_bit, tx_stop2;
    logic                   tx_accept_c, tx_tick_c, tx_bit_end_c;
    logic                   tx_d, tx_ready_d;

    assign tx_accept_c  = tx_valid && (tx_state == TX_IDLE);
    assign tx_tick_c    = (tx_state != TX_IDLE) && (tx_div_cnt == tx_div - DIV_ONE);
    assign tx_bit_end_c = tx_tick_c && (tx_tick_cnt == 4'd15);

    // State register, frame configuration and tick divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            tx_div      <= '0;
            tx_div_cnt  <= '0;
            tx_tick_cnt <= '0;
            tx_idx      <= '0;
            tx_shreg    <= '0;
            tx_par_en   <= 1'b0;
            tx_par_bit  <= 1'b0;
            tx_stop2    <= 1'b0;
            tx          <= 1'b1;
            tx_ready    <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_idx   <= tx_idx_nxt;
            tx_shreg <= tx_shreg_nxt;
            tx       <= tx_d;
            tx_ready <= tx_ready_d;
            if (tx_accept_c) begin
                tx_div      <= div_eff_c;
                tx_div_cnt  <= '0;
                tx_tick_cnt <= '0;
                tx_par_en   <= par_en_c;
                tx_par_bit  <= (^tx_data) ^ parity_mode[1];
                tx_stop2    <= stop2;
            end else if (tx_tick_c) begin
                tx_div_cnt  <= '0;
                tx_tick_cnt <= tx_tick_cnt + 4'd1;
            end else if (tx_state != TX_IDLE) begin
                tx_div_cnt  <= tx_div_cnt + DIV_ONE;
            end
        end
    end

    // Next-state: every state lasts 16 ticks; DATA repeats per payload bit.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_idx_nxt   = tx_idx;
        tx_shreg_nxt = tx_shreg;
        case (tx_state)
            TX_IDLE: begin
                if (tx_accept_c) begin
                    tx_state_nxt = TX_START;
                    tx_idx_nxt   = '0;
                    tx_shreg_nxt = tx_data;
                end
            end
            TX_START: begin
                if (tx_bit_end_c) tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                if (tx_bit_end_c) begin
                    if (tx_idx == LAST_IDX) begin
                        tx_state_nxt = tx_par_en ? TX_PARITY : TX_STOP1;
                    end else begin
                        tx_idx_nxt   = tx_idx + IDX_ONE;
                        tx_shreg_nxt = {1'b0, tx_shreg[DATA_BITS-1:1]};
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end_c) tx_state_nxt = TX_STOP1;
            end
            TX_STOP1: begin
                if (tx_bit_end_c) tx_state_nxt = tx_stop2 ? TX_STOP2 : TX_IDLE;
            end
            TX_STOP2: begin
                if (tx_bit_end_c) tx_state_nxt = TX_IDLE;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the line moves with the state.
    always_comb begin
        tx_d       = 1'b1;
        tx_ready_d = 1'b0;
        case (tx_state_nxt)
            TX_IDLE:   tx_ready_d = 1'b1;
            TX_START:  tx_d       = 1'b0;
            TX_DATA:   tx_d       = tx_shreg_nxt[0];
            TX_PARITY: tx_d       = tx_par_bit;
            default:   tx_d       = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    rx_state_t              rx_state, rx_state_nxt;
    logic                   rx_s1, rx_s2, rx_prev;
    logic [DIV_W-1:0]       rx_div, rx_div_cnt;
    logic [3:0]             rx_tick_cnt;
    logic [IDX_W-1:0]       rx_idx, rx_idx_nxt;
    logic [DATA_BITS-1:0]   rx_shreg, rx_shreg_nxt;
    logic                   rx_par_en, rx_par_odd, rx_par_smp, rx_par_smp_nxt;
    logic                   rx_start_c, rx_tick_c, rx_sample_c;
    logic                   rx_valid_d, rx_busy_d, rx_perr_d;

    // Falling edge of the synchronised line starts a frame only from idle.
    assign rx_start_c  = (rx_state == RX_IDLE) && rx_prev && !rx_s2;
    assign rx_tick_c   = (rx_state != RX_IDLE) && (rx_div_cnt == rx_div - DIV_ONE);
    // Start bit is sampled at 8 ticks (mid-bit); the tick count then restarts
    // so every later sample lands 16 ticks on, also mid-bit.
    assign rx_sample_c = rx_tick_c &&
                         ((rx_state == RX_START) ? (rx_tick_cnt == 4'd7)
                                                 : (rx_tick_cnt == 4'd15));

    // State register, synchroniser, frame configuration and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state      <= RX_IDLE;
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            rx_prev       <= 1'b1;
            rx_div        <= '0;
            rx_div_cnt    <= '0;
            rx_tick_cnt   <= '0;
            rx_idx        <= '0;
            rx_shreg      <= '0;
            rx_par_en     <= 1'b0;
            rx_par_odd    <= 1'b0;
            rx_par_smp    <= 1'b0;
            rx_valid      <= 1'b0;
            rx_busy       <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            rx_state   <= rx_state_nxt;
            rx_idx     <= rx_idx_nxt;
            rx_shreg   <= rx_shreg_nxt;
            rx_par_smp <= rx_par_smp_nxt;
            rx_valid   <= rx_valid_d;
            rx_busy    <= rx_busy_d;
            if (rx_valid_d) begin
                rx_data       <= rx_shreg;
                rx_parity_err <= rx_perr_d;
                rx_frame_err  <= !rx_s2;
            end
            if (rx_start_c) begin
                rx_div      <= div_eff_c;
                rx_div_cnt  <= '0;
                rx_tick_cnt <= '0;
                rx_par_en   <= par_en_c;
                rx_par_odd  <= parity_mode[1];
            end else if (rx_tick_c) begin
                rx_div_cnt  <= '0;
                rx_tick_cnt <= (rx_state == RX_START && rx_sample_c) ? 4'd0
                                                                     : rx_tick_cnt + 4'd1;
            end else if (rx_state != RX_IDLE) begin
                rx_div_cnt  <= rx_div_cnt + DIV_ONE;
            end
        end
    end

    // Next-state and sample capture.
    always_comb begin
        rx_state_nxt   = rx_state;
        rx_idx_nxt     = rx_idx;
        rx_shreg_nxt   = rx_shreg;
        rx_par_smp_nxt = rx_par_smp;
        case (rx_state)
            RX_IDLE: begin
                if (rx_start_c) begin
                    rx_state_nxt = RX_START;
                    rx_idx_nxt   = '0;
                end
            end
            RX_START: begin
                if (rx_sample_c) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_sample_c) begin
                    rx_shreg_nxt = {rx_s2, rx_shreg[DATA_BITS-1:1]};
                    if (rx_idx == LAST_IDX) begin
                        rx_state_nxt = rx_par_en ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_idx_nxt = rx_idx + IDX_ONE;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample_c) begin
                    rx_par_smp_nxt = rx_s2;
                    rx_state_nxt   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample_c) rx_state_nxt = RX_IDLE;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // Output decode: completion pulse, busy flag and parity check.
    always_comb begin
        rx_valid_d = (rx_state == RX_STOP) && rx_sample_c;
        rx_busy_d  = (rx_state_nxt != RX_IDLE);
        rx_perr_d  = rx_par_en && (rx_par_smp != ((^rx_shreg) ^ rx_par_odd));
    end

endmodule
